fifo_mem_ctrl: RTL and testbench
================================

FIFO_MEM_CTRL -- requirements
Module: fifo_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning storage depth of 2^ADDR_W words (8 by default).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port arst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port push  input  1  write request from the upstream write-side FSM.
REQ-006 The block SHALL have port din  input  DATA_W  write data, sampled with push.
REQ-007 The block SHALL have port pop  input  1  read request from the downstream read-side FSM.
REQ-008 The block SHALL have port dout  output  DATA_W  registered read data.
REQ-009 The block SHALL have port Full  output  1  high when 2^ADDR_W words are stored.
REQ-010 The block SHALL have port Empty  output  1  high when zero words are stored.
REQ-011 The block SHALL have port count  output  ADDR_W+1  number of stored words, 0 to 2^ADDR_W.
REQ-012 The block SHALL have ports overflow and underflow  output  1 each  sticky error flags, present only under FIFO_ERR_FLAGS_EN.

Function
REQ-013 The block SHALL hold 2^ADDR_W words of DATA_W bits in an internal array, with no reset applied to the array contents.
REQ-014 The block SHALL keep write and read pointers of ADDR_W+1 bits each; the low ADDR_W bits index the array and the MSB is the wrap bit.
REQ-015 A push SHALL be accepted iff push=1 and Full=0; an accepted push writes din to mem[wr_ptr] and increments wr_ptr modulo 2^(ADDR_W+1).
REQ-016 A pop SHALL be accepted iff pop=1 and Empty=0; an accepted pop loads mem[rd_ptr] into dout at that clock edge and increments rd_ptr, so data is visible one cycle after the pop request.
REQ-017 dout SHALL hold its value in every cycle without an accepted pop.
REQ-018 Empty SHALL equal (wr_ptr == rd_ptr).
REQ-019 Full SHALL equal (wr_ptr MSB != rd_ptr MSB) and (wr_ptr low bits == rd_ptr low bits).
REQ-020 count SHALL equal wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
REQ-021 Full, Empty and count SHALL be decoded from registered pointers only, with no combinational path from push or pop.
REQ-022 Simultaneous push and pop when neither Full nor Empty SHALL both be accepted, leaving count unchanged.
REQ-023 Simultaneous push and pop while Empty SHALL accept only the push; the pop is ignored and dout holds.
REQ-024 Simultaneous push and pop while Full SHALL accept only the pop; the push is dropped and din is not written.
REQ-025 Pointer wrap from index 2^ADDR_W-1 to 0 SHALL toggle the wrap bit, with no loss of data or flag glitch.

Reset
REQ-026 When arst=1 at a rising clk edge, the block SHALL set wr_ptr=0, rd_ptr=0, dout=0, count=0, Empty=1, Full=0 and (when compiled in) overflow=0 and underflow=0.
REQ-027 arst SHALL take priority over push and pop in the same cycle; a push or pop coincident with reset is discarded.
REQ-028 A reset asserted mid-operation SHALL discard all stored words logically, with Empty=1 in the first cycle after the reset edge.

Configuration
REQ-029 With macro FIFO_ERR_FLAGS_EN defined, overflow SHALL set on any cycle with push=1 and Full=0-not-satisfied (Full=1 and the push is rejected), and underflow SHALL set on any cycle with pop=1 and Empty=1; both SHALL remain set until arst.
REQ-030 Without FIFO_ERR_FLAGS_EN, the overflow and underflow ports and their logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Verification (DATA_W=8, ADDR_W=3)
REQ-031 Scenario: reset, then push 0xA5 for one cycle, then pop for one cycle -> Empty goes 1→0→1, count goes 0→1→0, and dout=0xA5 in the cycle after the pop.
REQ-032 Scenario: push 0x01..0x08 on consecutive cycles -> Full=1 and count=8 after the 8th push; a 9th push of 0xFF is dropped and overflow=1 (macro on).
REQ-033 Scenario: drain the full FIFO from REQ-032 -> dout sequence is 0x01..0x08, then Empty=1; one extra pop leaves dout=0x08 and sets underflow=1.
REQ-034 Scenario: run 20 cycles of push+pop at half full (count=4) -> count stays 4 and output order equals input order across pointer wrap.
REQ-035 Scenario: push+pop while Empty, and push+pop while Full -> count becomes 1 in the first case and 7 in the second.
REQ-036 Scenario: arst asserted with count=5 and a coincident push -> next cycle count=0, Empty=1, dout=0x00, error flags cleared.

Source files
------------

// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: synchronous single-clock FIFO with registered read data.
// Storage is 2^ADDR_W words of DATA_W bits. Pointers carry an extra wrap bit
// so Full and Empty can be told apart when the index bits are equal.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module fifo_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              Full,
    output logic              Empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Status is decoded from the registered pointers only.
    assign Empty = (wr_ptr == rd_ptr);
    assign Full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Reset wins over requests; a rejected request leaves all state alone.
    assign push_ok = push && !Full && !arst;
    assign pop_ok  = pop && !Empty && !arst;

    // Storage write; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    // Pointer advance and registered read data.
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                dout   <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags: set on any rejected request, cleared only by reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && Full) begin
                overflow <= 1'b1;
            end
            if (pop && Empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl (DATA_W=8, ADDR_W=3) with a queue model.
module tb_fifo_mem_ctrl;

    logic       clk;
    logic       arst;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       Full;
    logic       Empty;
    logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;

    fifo_mem_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .arst      (arst),
        .push      (push),
        .din       (din),
        .pop       (pop),
        .dout      (dout),
        .Full      (Full),
        .Empty     (Empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"},  {24'd0, dout}, {24'd0, exp_dout});
        chk({tag, ".count"}, {28'd0, count}, model_q.size());
        chk({tag, ".empty"}, {31'd0, Empty}, (model_q.size() == 0) ? 32'd1 : 32'd0);
        chk({tag, ".full"},  {31'd0, Full},  (model_q.size() == 8) ? 32'd1 : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".ovf"}, {31'd0, overflow},  {31'd0, exp_ovf});
        chk({tag, ".unf"}, {31'd0, underflow}, {31'd0, exp_unf});
`endif
    endtask

    // One clock of push/pop with model update after the edge.
    task automatic step(input string tag, input logic p, input logic q, input logic [7:0] d);
        bit full_m;
        bit empty_m;
        full_m  = (model_q.size() == 8);
        empty_m = (model_q.size() == 0);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        if (q && !empty_m) exp_dout = model_q.pop_front();
        if (p && !full_m)  model_q.push_back(d);
        if (p && full_m)   exp_ovf = 1'b1;
        if (q && empty_m)  exp_unf = 1'b1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic p);
        arst = 1'b1;
        push = p;
        pop  = 1'b0;
        din  = 8'h5A;
        @(posedge clk);
        #1;
        arst = 1'b0;
        push = 1'b0;
        model_q.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        arst = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = 8'h00;
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;

        do_reset("reset", 1'b0);

        // single word round trip
        step("push_a5", 1'b1, 1'b0, 8'hA5);
        step("pop_a5",  1'b0, 1'b1, 8'h00);

        // fill to full, then one dropped push
        for (int i = 1; i <= 8; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, 8'(i));
        step("push_when_full", 1'b1, 1'b0, 8'hFF);

        // drain, then one pop while empty
        for (int i = 1; i <= 8; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00);
        step("pop_when_empty", 1'b0, 1'b1, 8'h00);

        // push+pop while empty: only push accepted
        step("pp_empty", 1'b1, 1'b1, 8'h33);
        step("pop_33",   1'b0, 1'b1, 8'h00);

        // push+pop while full: only pop accepted
        for (int i = 0; i < 8; i++) step($sformatf("refill%0d", i), 1'b1, 1'b0, 8'(8'h40 + i));
        step("pp_full", 1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < 7; i++) step($sformatf("redrain%0d", i), 1'b0, 1'b1, 8'h00);

        // half-full streaming across pointer wrap
        for (int i = 0; i < 4; i++) step($sformatf("half%0d", i), 1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 20; i++) step($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(8'h20 + i));

        // reset mid-operation with coincident push at count=5
        step("to_five", 1'b1, 1'b0, 8'h77);
        do_reset("reset_mid", 1'b1);

        // post-reset sanity
        step("post_push", 1'b1, 1'b0, 8'hC3);
        step("post_pop",  1'b0, 1'b1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
